// File: rtl/board_io_pkg.sv
// Shared constants, state types and segment encoding for the board console.
package board_io_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    typedef enum logic {IN_IDLE, IN_WAIT_PRESS} in_state_e;
    typedef enum logic {OUT_IDLE, OUT_CONV} out_state_e;

    // Active-low seven-segment code, segments a..g on bits 0..6.
    function automatic logic [6:0] seg_of(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // Decimal digit count of 2**w (1233/4096 approximates log10(2)).
    function automatic int bcd_digits(input int w);
        return (w * 1233) / 4096 + 1;
    endfunction

endpackage

// File: rtl/board_io_unit_button_conditioner.sv
// Two-flop synchroniser, debounce filter and press-edge pulse for one
// active-low push-button.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_n_i,
    output logic press_o
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync1_q, sync2_q, level_q, press_q;
    logic [CNT_W-1:0] cnt_q;

    // A single-bit level can only bounce back to the accepted level, so
    // "equal to accepted level" doubles as the counter restart condition.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_n_i;
            sync2_q <= sync1_q;
            press_q <= 1'b0;
            if (sync2_q == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level_q <= sync2_q;
                cnt_q   <= '0;
                press_q <= ~sync2_q;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/board_io_unit.sv
// Board console: button conditioning, switch-input handshake and a
// sequential double-dabble driving signed seven-segment output.
module board_io_unit
    import board_io_pkg::*;
#(
    parameter int DATA_W          = 16,
    parameter int SW_W            = 15,
    parameter int DIGITS          = 3,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int BLANK_LZ        = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enter,
    input  logic                  interruption,
    input  logic [SW_W-1:0]       switches,
    input  logic                  in_req,
    output logic [DATA_W-1:0]     in_data,
    output logic                  in_valid,
    input  logic                  out_we,
    input  logic [DATA_W-1:0]     out_data,
    output logic                  out_busy,
    output logic                  irq_pulse,
    output logic [7*DIGITS-1:0]   hex,
    output logic [6:0]            hex_neg,
    output logic                  led
);
    localparam int BCD_DIGITS = bcd_digits(DATA_W);
    localparam int BCD_W      = 4 * BCD_DIGITS;
    localparam int ITER_W     = $clog2(DATA_W + 1);

    logic enter_press, irq_press;

    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
        .clock(clock), .reset(reset), .btn_n_i(enter), .press_o(enter_press)
    );
    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_irq (
        .clock(clock), .reset(reset), .btn_n_i(interruption), .press_o(irq_press)
    );

    logic irq_q;
    always_ff @(posedge clock) begin
        if (reset) irq_q <= 1'b0;
        else       irq_q <= irq_press;
    end
    assign irq_pulse = irq_q;

    // Input handshake
    in_state_e          in_state_q, in_state_d;
    logic               led_q, led_d, in_valid_q, in_valid_d;
    logic [DATA_W-1:0]  in_data_q, in_data_d;

    always_comb begin
        in_state_d = in_state_q;
        led_d      = led_q;
        in_valid_d = 1'b0;
        in_data_d  = in_data_q;
        case (in_state_q)
            IN_IDLE: begin
                if (in_req) begin
                    in_state_d = IN_WAIT_PRESS;
                    led_d      = 1'b1;
                end
            end
            IN_WAIT_PRESS: begin
                if (!in_req) begin
                    in_state_d = IN_IDLE;
                    led_d      = 1'b0;
                end else if (enter_press) begin
                    in_state_d = IN_IDLE;
                    led_d      = 1'b0;
                    in_valid_d = 1'b1;
                    in_data_d  = DATA_W'(switches);
                end
            end
            default: in_state_d = IN_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            in_state_q <= IN_IDLE;
            led_q      <= 1'b0;
            in_valid_q <= 1'b0;
            in_data_q  <= '0;
        end else begin
            in_state_q <= in_state_d;
            led_q      <= led_d;
            in_valid_q <= in_valid_d;
            in_data_q  <= in_data_d;
        end
    end

    assign led      = led_q;
    assign in_valid = in_valid_q;
    assign in_data  = in_data_q;

    // Display conversion
    out_state_e          out_state_q, out_state_d;
    logic                sign_q, sign_d;
    logic [DATA_W-1:0]   bin_q, bin_d;
    logic [BCD_W-1:0]    bcd_q, bcd_d, bcd_adj;
    logic [BCD_W:0]      bcd_wide;
    logic [ITER_W-1:0]   iter_q, iter_d;
    logic [7*DIGITS-1:0] hex_q, hex_d, hex_next;
    logic [6:0]          hex_neg_q, hex_neg_d, neg_next;
    logic                overflow;

    for (genvar gi = 0; gi < BCD_DIGITS; gi++) begin : g_adj
        assign bcd_adj[4*gi +: 4] = (bcd_q[4*gi +: 4] >= 4'd5) ?
                                    bcd_q[4*gi +: 4] + 4'd3 : bcd_q[4*gi +: 4];
    end

    // Result of the current iteration; on the last one it is the final BCD.
    assign bcd_wide = {bcd_adj, bin_q[DATA_W-1]};
    assign overflow = (bcd_wide >> (4 * DIGITS)) != '0;

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_seg
        logic lead_zero;
        assign lead_zero = (gi != 0) && (BLANK_LZ != 0) &&
                           ((bcd_wide[4*DIGITS-1:0] >> (4 * gi)) == '0);
        assign hex_next[7*gi +: 7] = overflow  ? SEG_DASH  :
                                     lead_zero ? SEG_BLANK :
                                     seg_of(bcd_wide[4*gi +: 4]);
    end

    assign neg_next = (sign_q && !overflow) ? SEG_DASH : SEG_BLANK;

    always_comb begin
        out_state_d = out_state_q;
        sign_d      = sign_q;
        bin_d       = bin_q;
        bcd_d       = bcd_q;
        iter_d      = iter_q;
        hex_d       = hex_q;
        hex_neg_d   = hex_neg_q;
        case (out_state_q)
            OUT_IDLE: begin
                if (out_we) begin
                    out_state_d = OUT_CONV;
                    sign_d      = out_data[DATA_W-1];
                    // Negating the most negative value wraps to 2**(DATA_W-1), which is exact unsigned.
                    bin_d       = out_data[DATA_W-1] ? -out_data : out_data;
                    bcd_d       = '0;
                    iter_d      = '0;
                end
            end
            OUT_CONV: begin
                bcd_d  = bcd_wide[BCD_W-1:0];
                bin_d  = bin_q << 1;
                iter_d = iter_q + ITER_W'(1);
                if (iter_q == ITER_W'(DATA_W - 1)) begin
                    out_state_d = OUT_IDLE;
                    hex_d       = hex_next;
                    hex_neg_d   = neg_next;
                end
            end
            default: out_state_d = OUT_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out_state_q <= OUT_IDLE;
            sign_q      <= 1'b0;
            bin_q       <= '0;
            bcd_q       <= '0;
            iter_q      <= '0;
            hex_q       <= {DIGITS{SEG_BLANK}};
            hex_neg_q   <= SEG_BLANK;
        end else begin
            out_state_q <= out_state_d;
            sign_q      <= sign_d;
            bin_q       <= bin_d;
            bcd_q       <= bcd_d;
            iter_q      <= iter_d;
            hex_q       <= hex_d;
            hex_neg_q   <= hex_neg_d;
        end
    end

    assign out_busy = (out_state_q == OUT_CONV);
    assign hex      = hex_q;
    assign hex_neg  = hex_neg_q;

endmodule

// File: doc/board_io_unit.md
Name: board_io_unit

Overview:
Parametrised board console for the processor. It conditions the enter and interruption push-buttons and runs an input handshake that captures the switches on an enter press. It also converts a signed processor result into DIGITS seven-segment digits plus a sign display, using a sequential double-dabble. It sits between the processor core and the board pins, replacing ad-hoc pin wiring with a defined handshake.

Parameters:
DATA_W, 16, width of in_data/out_data (two's complement on output path)
SW_W, 15, switch count (SW_W <= DATA_W)
DIGITS, 3, decimal digits shown (ones first)
DEBOUNCE_CYCLES, 50000, consecutive stable cycles before a button level is accepted
BLANK_LZ, 1, 1 = blank leading zeros (ones digit never blanked)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
enter  in  1  raw push-button, active-low, asynchronous
interruption  in  1  raw push-button, active-low, asynchronous
switches  in  SW_W  raw switch levels
in_req  in  1  processor requests an input value; held until in_valid
in_data  out  DATA_W  captured switches, zero-extended; holds last value
in_valid  out  1  one-cycle pulse, in_data valid
out_we  in  1  write out_data to display (accepted only when out_busy=0)
out_data  in  DATA_W  signed value to display
out_busy  out  1  conversion in progress
irq_pulse  out  1  one-cycle pulse per debounced interruption press
hex  out  7*DIGITS  digit i at [7*i +: 7], i=0 ones; segments a..g = bits 0..6, active-low
hex_neg  out  7  sign display, active-low
led  out  1  1 while waiting for an enter press

Behaviour:
- Reset (synchronous, every cycle asserted): hex and hex_neg all 7'h7F (blank); led, in_valid, out_busy, irq_pulse = 0; in_data = 0; debounced levels = released; input FSM to IDLE; any conversion aborted.
- Button path: 2-flop sync; counter restarts on any sync-level change. Level accepted after DEBOUNCE_CYCLES unchanged cycles. A press edge (released->pressed) is a one-cycle pulse. Holding a button gives exactly one edge.
- irq_pulse = interruption press edge, registered, 1 cycle.
- Input FSM states IDLE, WAIT_PRESS:
  IDLE: in_req=1 -> WAIT_PRESS next cycle, led=1. A press edge in IDLE, including one in the same cycle as in_req rising, is ignored.
  WAIT_PRESS: enter press edge -> in_data <= zero-extended switches (sampled that cycle), in_valid=1 next cycle, led=0, -> IDLE. in_req=0 -> abort to IDLE, led=0, no in_valid.
- Output path states IDLE, CONV:
  out_we=1 and out_busy=0 at edge t: latch sign and magnitude (|x| as DATA_W-bit unsigned; -2^(DATA_W-1) is exact). out_busy=1 from t+1.
  CONV: one shift-add-3 iteration per cycle, DATA_W iterations. At the final edge, hex/hex_neg load and out_busy falls together. out_busy is high exactly DATA_W cycles.
  out_we while out_busy=1 is dropped (no queue). Display holds the previous value until the final edge.
- Internal BCD width = enough digits for 2^DATA_W. Overflow = any digit above DIGITS-1 nonzero -> all DIGITS show dash 7'b0111111, hex_neg blank.
- Sign: hex_neg = 7'b0111111 (dash) when the value is negative and in range; otherwise blank. Value 0 shows "0" with no sign.
- Digit codes: 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 (hex, active-low). With BLANK_LZ=1, zero digits above the most significant nonzero digit show 7F.

Decomposition:
- Package board_io_pkg: SEG_BLANK, SEG_DASH, digit-to-segment function, FSM state enums.
- Sub-module button_conditioner (sync + debounce + press edge, parameter DEBOUNCE_CYCLES), instanced for enter and interruption.

Test Plan:
(All with DEBOUNCE_CYCLES=4, DATA_W=16, DIGITS=3.)
- Reset mid-conversion (assert reset during CONV) -> hex=all 7F, hex_neg=7F, out_busy=0, led=0 next cycle; no display update afterwards.
- out_we, out_data=-42 -> out_busy high exactly 16 cycles, then hex[20:14]=7F, hex[13:7]=19, hex[6:0]=24, hex_neg=3F. out_we=7 during busy is ignored.
- out_data=1000 and out_data=-32768 -> all three digits 3F, hex_neg=7F. out_data=0 -> ones=40, others 7F, hex_neg=7F.
- in_req=1, switches=15'h1234, enter pressed and held 50 cycles -> led=1 until the press is accepted, then exactly one in_valid pulse with in_data=16'h1234; led=0 afterwards.
- Enter bouncing (toggle every 2 cycles for 20 cycles) in WAIT_PRESS -> no in_valid. Then stable low -> exactly one in_valid. Dropping in_req before the press -> led=0, no in_valid.
- interruption held low 100 cycles -> exactly one irq_pulse, occurring 2+4+1 cycles after the low level first reaches the pin sample.
